instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Instruction-fetch stage. Owns the program counter and drives it as the byte address to the
//   combinational instruction memory. Captures the returned instruction word into the IF/ID
//   pipeline register for decode. Handles stall, branch/jump redirect, halt and the reset vector.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC loaded on reset; must be word aligned
//   IMEM_WORDS    1024           instruction memory depth in 32-bit words
//   NOP_INS       32'h0000_0013  bubble encoding (addi x0,x0,0)
// PORTS
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous, active-low reset
//   stall_i        in   1   decode cannot accept; hold PC and IF/ID
//   redirect_i     in   1   taken branch/jump from execute
//   redirect_pc_i  in   32  redirect target byte address
//   halt_i         in   1   stop fetching after the current cycle
//   pc_addr_o      out  32  byte address to instruction memory (= PC register)
//   ins_i          in   32  instruction word returned combinationally for pc_addr_o
//   id_valid_o     out  1   IF/ID holds a real instruction
//   id_ins_o       out  32  IF/ID instruction (NOP_INS when not valid)
//   id_pc_o        out  32  IF/ID PC of id_ins_o
//   id_pc4_o       out  32  IF/ID id_pc_o + 4
//   halted_o       out  1   FSM in HALT
// BEHAVIOUR
//   Reset (async, any time, incl. mid-redirect): PC=RESET_VECTOR, state=BOOT, id_valid_o=0,
//     id_ins_o=NOP_INS, id_pc_o=RESET_VECTOR, id_pc4_o=RESET_VECTOR+4, halted_o=0.
//   FSM (3 states):
//     BOOT: one cycle, no capture; -> RUN.
//     RUN: fetch each cycle.
//     HALT: PC held; IF/ID bubble.
//   RUN priority per edge: redirect_i > stall_i > halt_i > advance.
//     redirect: PC<=redirect_pc_i; IF/ID<=bubble (valid 0, NOP_INS); overrides a simultaneous
//       stall (the stalled IF/ID entry is on the wrong path).
//     stall: PC and IF/ID hold every field.
//     halt: IF/ID<=bubble; PC held; -> HALT.
//     advance: IF/ID<={1,ins_i,PC,PC+4}; PC<=PC+4.
//   HALT: redirect_i -> RUN with PC<=redirect_pc_i; stall_i and halt_i are ignored.
//   Latency: PC presented at cycle n appears on the id_* outputs after edge n+1. The first valid
//     id_* appears two edges after rst_n deasserts.
//   Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
//   Out of range: PC >= IMEM_WORDS*4 captures a bubble (valid 0) in place of ins_i; PC still
//     advances.
//   redirect_pc_i[1:0] is ignored: PC<={redirect_pc_i[31:2],2'b00}, unless the macro below is
//     defined.
// CONFIGURATION
//   FETCH_MISALIGN_CHECK_EN defined:
//     Adds output port misalign_o (1 bit, reset 0).
//     A redirect with redirect_pc_i[1:0]!=0 sets misalign_o=1 and enters HALT (PC unchanged).
//     misalign_o clears only on the next accepted redirect.
//   Undefined: no port; the target is silently aligned as described above.
// STRUCTURE
//   Package fetch_pkg: NOP_INS constant, fetch_state_t enum {BOOT,RUN,HALT}, word-size localparam.
//   Sub-module fetch_next_pc (combinational): selects next PC and bubble/capture for the register.
//   The top level holds the PC, FSM and IF/ID registers.
// TESTING
//   Reset release, mem[0]=32'h00500093, mem[1]=32'h00A00113:
//     -> pc_addr_o 0,4,8.
//     -> id_valid_o 0 for two edges, then id_ins_o=00500093 with id_pc_o=0.
//     -> next edge id_ins_o=00A00113 with id_pc_o=4.
//   stall_i high 3 cycles at PC=8 -> pc_addr_o stays 8; id_* constant; resumes at 12 after drop.
//   redirect_i with redirect_pc_i=0x40, same cycle as stall_i:
//     -> next edge PC=0x40, id_valid_o=0, id_ins_o=NOP_INS.
//     -> following edge id_pc_o=0x40.
//   halt_i pulse -> halted_o=1 and PC frozen; stall_i toggling has no effect;
//     redirect 0x10 -> RUN and fetch from 0x10.
//   PC reaches IMEM_WORDS*4 (0x1000):
//     -> id_valid_o=0 bubbles while PC keeps incrementing.
//     -> rst_n asserted mid-sequence clears everything asynchronously, before the next edge.
//   With FETCH_MISALIGN_CHECK_EN: redirect to 0x42 -> misalign_o=1, halted_o=1, PC unchanged;
//     redirect 0x44 -> misalign_o=0 and PC=0x44.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] NOP_INS    = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-state logic for instruction fetch: picks the next PC,
// the next FSM state and what the IF/ID register should load.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect halts).
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] BUBBLE_INS = NOP_INS
) (
    input  fetch_state_t i_state,
    input  logic [31:0]  i_pc,
    input  logic [31:0]  i_ins,
    input  logic         i_stall,
    input  logic         i_redirect,
    input  logic [31:0]  i_redirect_pc,
    input  logic         i_halt,
    output logic [31:0]  o_pc_nxt,
    output fetch_state_t o_state_nxt,
    output logic         o_id_load,     // update valid/ins fields
    output logic         o_id_cap_pc,   // also update pc/pc4 fields
    output logic         o_id_valid,
    output logic [31:0]  o_id_ins
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic         o_mis_set,
    output logic         o_mis_clr
`endif
);

    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'(WORD_BYTES);

    logic        w_in_range;
    logic [31:0] w_tgt;
    logic        w_redir_ok;

    assign w_in_range = ({1'b0, i_pc} < IMEM_BYTES);
    assign w_tgt      = i_redirect_pc & ~(WORD_BYTES - 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic w_redir_seen;
    assign w_redir_ok   = ((i_redirect_pc & (WORD_BYTES - 32'd1)) == 32'd0);
    assign w_redir_seen = i_redirect && (i_state == RUN || i_state == HALT);
    assign o_mis_set    = w_redir_seen && !w_redir_ok;
    assign o_mis_clr    = w_redir_seen &&  w_redir_ok;
`else
    assign w_redir_ok   = 1'b1;
`endif

    // Priority in RUN: redirect > stall > halt > advance; HALT only listens to redirect
    always_comb begin
        o_pc_nxt    = i_pc;
        o_state_nxt = i_state;
        o_id_load   = 1'b0;
        o_id_cap_pc = 1'b0;
        o_id_valid  = 1'b0;
        o_id_ins    = BUBBLE_INS;
        case (i_state)
            BOOT: o_state_nxt = RUN;
            RUN: begin
                if (i_redirect) begin
                    // the stalled IF/ID entry is wrong-path, so bubble it
                    o_id_load = 1'b1;
                    if (w_redir_ok) o_pc_nxt    = w_tgt;
                    else            o_state_nxt = HALT;
                end else if (i_stall) begin
                    o_id_load = 1'b0;
                end else if (i_halt) begin
                    o_id_load   = 1'b1;
                    o_state_nxt = HALT;
                end else begin
                    o_id_load   = 1'b1;
                    o_id_cap_pc = 1'b1;
                    o_pc_nxt    = i_pc + WORD_BYTES;
                    if (w_in_range) begin
                        o_id_valid = 1'b1;
                        o_id_ins   = i_ins;
                    end
                end
            end
            HALT: begin
                o_id_load = 1'b1;
                if (i_redirect && w_redir_ok) begin
                    o_pc_nxt    = w_tgt;
                    o_state_nxt = RUN;
                end
            end
            default: o_state_nxt = BOOT;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT FSM and IF/ID register.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds misalign_o.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 1024,
    parameter logic [31:0] NOP_INS      = fetch_pkg::NOP_INS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [31:0] pc_addr_o,
    input  logic [31:0] ins_i,
    output logic        id_valid_o,
    output logic [31:0] id_ins_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic        halted_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);
    import fetch_pkg::*;

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_id_valid, w_id_valid;
    logic [31:0]  r_id_ins, w_id_ins;
    logic [31:0]  r_id_pc, r_id_pc4;
    logic         w_id_load, w_id_cap_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign, w_mis_set, w_mis_clr;
`endif

    fetch_next_pc #(
        .IMEM_WORDS (IMEM_WORDS),
        .BUBBLE_INS (NOP_INS)
    ) u_next_pc (
        .i_state       (r_state),
        .i_pc          (r_pc),
        .i_ins         (ins_i),
        .i_stall       (stall_i),
        .i_redirect    (redirect_i),
        .i_redirect_pc (redirect_pc_i),
        .i_halt        (halt_i),
        .o_pc_nxt      (w_pc_nxt),
        .o_state_nxt   (w_state_nxt),
        .o_id_load     (w_id_load),
        .o_id_cap_pc   (w_id_cap_pc),
        .o_id_valid    (w_id_valid),
        .o_id_ins      (w_id_ins)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .o_mis_set     (w_mis_set),
        .o_mis_clr     (w_mis_clr)
`endif
    );

    // PC and FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_VECTOR;
            r_state <= BOOT;
        end else begin
            r_pc    <= w_pc_nxt;
            r_state <= w_state_nxt;
        end
    end

    // IF/ID register; bubbles keep the last pc/pc4 fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_ins   <= NOP_INS;
            r_id_pc    <= RESET_VECTOR;
            r_id_pc4   <= RESET_VECTOR + WORD_BYTES;
        end else begin
            if (w_id_load) begin
                r_id_valid <= w_id_valid;
                r_id_ins   <= w_id_ins;
            end
            if (w_id_cap_pc) begin
                r_id_pc  <= r_pc;
                r_id_pc4 <= r_pc + WORD_BYTES;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky misalign flag, cleared by the next accepted redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_misalign <= 1'b0;
        else if (w_mis_set) r_misalign <= 1'b1;
        else if (w_mis_clr) r_misalign <= 1'b0;
    end
    assign misalign_o = r_misalign;
`endif

    assign pc_addr_o  = r_pc;
    assign id_valid_o = r_id_valid;
    assign id_ins_o   = r_id_ins;
    assign id_pc_o    = r_id_pc;
    assign id_pc4_o   = r_id_pc4;
    assign halted_o   = (r_state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table driven through a
// scoreboard queue, plus hand sequences for async reset and misalign.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, redirect_i, halt_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_addr_o, ins_i;
    logic        id_valid_o, halted_o;
    logic [31:0] id_ins_o, id_pc_o, id_pc4_o;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    logic [31:0] mem [0:1023];

    instruction_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .pc_addr_o     (pc_addr_o),
        .ins_i         (ins_i),
        .id_valid_o    (id_valid_o),
        .id_ins_o      (id_ins_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .halted_o      (halted_o)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    // Combinational instruction memory; junk outside the array
    assign ins_i = (pc_addr_o < 32'h1000) ? mem[pc_addr_o[11:2]] : 32'hDEAD_BEEF;

    typedef struct {
        string       name;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ins;
        logic        chkpc;
        logic [31:0] idpc;
        logic        halted;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(string nm, logic st, logic rd, logic [31:0] rpc, logic hl,
                                logic [31:0] pc, logic v, logic [31:0] ins,
                                logic cp, logic [31:0] idpc, logic hd);
        vec_t r;
        r.name = nm; r.stall = st; r.redir = rd; r.rpc = rpc; r.halt = hl;
        r.pc = pc; r.valid = v; r.ins = ins; r.chkpc = cp; r.idpc = idpc; r.halted = hd;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic apply(vec_t v);
        vec_t e;
        stall_i       = v.stall;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        halt_i        = v.halt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.name, ".pc"},     pc_addr_o,  e.pc);
        chk({e.name, ".valid"},  {31'd0, id_valid_o}, {31'd0, e.valid});
        chk({e.name, ".ins"},    id_ins_o,   e.ins);
        chk({e.name, ".halted"}, {31'd0, halted_o},   {31'd0, e.halted});
        if (e.chkpc) begin
            chk({e.name, ".idpc"},  id_pc_o,  e.idpc);
            chk({e.name, ".idpc4"}, id_pc4_o, e.idpc + 32'd4);
        end
    endtask

    task automatic check_reset(string nm);
        chk({nm, ".pc"},     pc_addr_o, 32'h0);
        chk({nm, ".valid"},  {31'd0, id_valid_o}, 32'd0);
        chk({nm, ".ins"},    id_ins_o,  NOP);
        chk({nm, ".idpc"},   id_pc_o,   32'h0);
        chk({nm, ".idpc4"},  id_pc4_o,  32'h4);
        chk({nm, ".halted"}, {31'd0, halted_o}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk({nm, ".mis"},    {31'd0, misalign_o}, 32'd0);
`endif
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;

        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0; redirect_pc_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        //                 name     st rd rpc           hl pc            v  ins           cp idpc       hd
        tbl.push_back(mk("boot",    0, 0, 32'h0,        0, 32'h0,        0, NOP,          1, 32'h0,     0));
        tbl.push_back(mk("f0",      0, 0, 32'h0,        0, 32'h4,        1, 32'h00500093, 1, 32'h0,     0));
        tbl.push_back(mk("f1",      0, 0, 32'h0,        0, 32'h8,        1, 32'h00A00113, 1, 32'h4,     0));
        tbl.push_back(mk("stall1",  1, 0, 32'h0,        0, 32'h8,        1, 32'h00A00113, 1, 32'h4,     0));
        tbl.push_back(mk("stall2",  1, 0, 32'h0,        0, 32'h8,        1, 32'h00A00113, 1, 32'h4,     0));
        tbl.push_back(mk("stall3",  1, 0, 32'h0,        0, 32'h8,        1, 32'h00A00113, 1, 32'h4,     0));
        tbl.push_back(mk("resume",  0, 0, 32'h0,        0, 32'hC,        1, 32'h10000002, 1, 32'h8,     0));
        tbl.push_back(mk("redst",   1, 1, 32'h40,       0, 32'h40,       0, NOP,          0, 32'h0,     0));
        tbl.push_back(mk("f40",     0, 0, 32'h0,        0, 32'h44,       1, 32'h10000010, 1, 32'h40,    0));
        tbl.push_back(mk("halt",    0, 0, 32'h0,        1, 32'h44,       0, NOP,          0, 32'h0,     1));
        tbl.push_back(mk("hstall",  1, 0, 32'h0,        0, 32'h44,       0, NOP,          0, 32'h0,     1));
        tbl.push_back(mk("hhalt",   0, 0, 32'h0,        1, 32'h44,       0, NOP,          0, 32'h0,     1));
        tbl.push_back(mk("hredir",  1, 1, 32'h10,       0, 32'h10,       0, NOP,          0, 32'h0,     0));
        tbl.push_back(mk("f10",     0, 0, 32'h0,        0, 32'h14,       1, 32'h10000004, 1, 32'h10,    0));
        tbl.push_back(mk("redend",  0, 1, 32'hFF8,      0, 32'hFF8,      0, NOP,          0, 32'h0,     0));
        tbl.push_back(mk("fff8",    0, 0, 32'h0,        0, 32'hFFC,      1, 32'h100003FE, 1, 32'hFF8,   0));
        tbl.push_back(mk("fffc",    0, 0, 32'h0,        0, 32'h1000,     1, 32'h100003FF, 1, 32'hFFC,   0));
        tbl.push_back(mk("oor0",    0, 0, 32'h0,        0, 32'h1004,     0, NOP,          0, 32'h0,     0));
        tbl.push_back(mk("oor1",    0, 0, 32'h0,        0, 32'h1008,     0, NOP,          0, 32'h0,     0));
        run_table();

        // Async reset in the middle of a cycle with a redirect pending
        redirect_i = 1'b1; redirect_pc_i = 32'h80;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        check_reset("rst_hold");
        redirect_i = 1'b0; redirect_pc_i = '0;
        rst_n = 1'b1;

        tbl.push_back(mk("boot2",   0, 0, 32'h0,        0, 32'h0,        0, NOP,          1, 32'h0,     0));
        tbl.push_back(mk("g0",      0, 0, 32'h0,        0, 32'h4,        1, 32'h00500093, 1, 32'h0,     0));
        tbl.push_back(mk("redtop",  0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, NOP,          0, 32'h0,     0));
        tbl.push_back(mk("wrap",    0, 0, 32'h0,        0, 32'h0,        0, NOP,          0, 32'h0,     0));
        tbl.push_back(mk("postwr",  0, 0, 32'h0,        0, 32'h4,        1, 32'h00500093, 1, 32'h0,     0));
`ifndef FETCH_MISALIGN_CHECK_EN
        tbl.push_back(mk("align",   0, 1, 32'h4B,       0, 32'h48,       0, NOP,          0, 32'h0,     0));
        tbl.push_back(mk("f48",     0, 0, 32'h0,        0, 32'h4C,       1, 32'h10000012, 1, 32'h48,    0));
`endif
        run_table();

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect halts with PC unchanged; an aligned one recovers
        apply(mk("mis42",   0, 1, 32'h42, 0, 32'h4,  0, NOP, 0, 32'h0, 1));
        chk("mis42.flag", {31'd0, misalign_o}, 32'd1);
        apply(mk("mishold", 1, 0, 32'h0,  1, 32'h4,  0, NOP, 0, 32'h0, 1));
        chk("mishold.flag", {31'd0, misalign_o}, 32'd1);
        apply(mk("mis44",   0, 1, 32'h44, 0, 32'h44, 0, NOP, 0, 32'h0, 0));
        chk("mis44.flag", {31'd0, misalign_o}, 32'd0);
`endif

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard: got %0d leftover want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
